// File: rtl/bcd_disp_pkg.sv
// Shared definitions for the BCD 7-segment display path: segment patterns
// in active-high {g,f,e,d,c,b,a} form, scan FSM states and digit selectors.
package bcd_disp_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  typedef enum logic {
    ST_DEAD = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  typedef enum logic {
    DIG_UNITS = 1'b0,
    DIG_TENS  = 1'b1
  } digit_t;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-high 7-segment pattern; non-BCD
// nibbles (10-15) render as a dash.
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  always_comb begin
    pattern = SEG_DASH;
    case (nibble)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_7seg_scan_driver.sv
// Two-digit multiplexed 7-segment scan driver: per-frame snapshot of
// tens/units, dead gap between digits, optional leading-zero blanking.
module bcd_7seg_scan_driver
  import bcd_disp_pkg::*;
#(
  parameter int REFRESH_DIV    = 4,
  parameter int DEAD_CYCLES    = 1,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       blank_lz,
  input  logic [3:0] tens,
  input  logic [3:0] units,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_done
);

  localparam int CNT_MAX_A = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > 2) ? CNT_MAX_A : 2;
  localparam int CW        = $clog2(CNT_MAX);

  localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
  localparam logic          HAS_DEAD  = (DEAD_CYCLES > 0);
  localparam logic [6:0]    SEG_IDLE  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [1:0]    AN_IDLE   = (AN_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

  state_t        state;
  digit_t        digit_sel;
  logic [CW-1:0] cnt;
  logic [7:0]    snap;
  logic          blank_snap;

  logic       in_dead;
  logic       frame_start;
  logic [7:0] cur_snap;
  logic       cur_blank;
  logic [3:0] nibble;
  logic       tens_blanked;
  logic [6:0] pattern;
  logic [6:0] seg_lit;
  logic [1:0] an_hot;
  logic [1:0] an_lit;

  // The state register names the phase the next edge will display; with no
  // dead gap the DEAD encoding is simply treated as SHOW.
  always_comb begin
    in_dead     = HAS_DEAD && (state == ST_DEAD);
    frame_start = (cnt == '0) && (digit_sel == DIG_UNITS) &&
                  ((state == ST_DEAD) || !HAS_DEAD);
    // On the snapshot edge the register is still stale, so show the inputs directly.
    cur_snap     = frame_start ? {tens, units} : snap;
    cur_blank    = frame_start ? blank_lz : blank_snap;
    nibble       = (digit_sel == DIG_TENS) ? cur_snap[7:4] : cur_snap[3:0];
    tens_blanked = (digit_sel == DIG_TENS) && cur_blank && (cur_snap[7:4] == 4'd0);
    seg_lit      = (SEG_ACTIVE_LOW != 0) ? ~pattern : pattern;
    an_hot       = (digit_sel == DIG_TENS) ? 2'b10 : 2'b01;
    an_lit       = (AN_ACTIVE_LOW != 0) ? ~an_hot : an_hot;
  end

  bcd_to_7seg u_dec (
    .nibble  (nibble),
    .pattern (pattern)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_DEAD;
      digit_sel  <= DIG_UNITS;
      cnt        <= '0;
      snap       <= 8'h00;
      blank_snap <= 1'b0;
      seg        <= SEG_IDLE;
      an         <= AN_IDLE;
      frame_done <= 1'b0;
    end else if (!enable) begin
      state      <= ST_DEAD;
      digit_sel  <= DIG_UNITS;
      cnt        <= '0;
      seg        <= SEG_IDLE;
      an         <= AN_IDLE;
      frame_done <= 1'b0;
    end else begin
      if (frame_start) begin
        snap       <= {tens, units};
        blank_snap <= blank_lz;
      end
      if (in_dead) begin
        seg        <= SEG_IDLE;
        an         <= AN_IDLE;
        frame_done <= 1'b0;
        if (cnt == DEAD_LAST) begin
          cnt   <= '0;
          state <= ST_SHOW;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        seg        <= tens_blanked ? SEG_IDLE : seg_lit;
        an         <= tens_blanked ? AN_IDLE : an_lit;
        frame_done <= (digit_sel == DIG_TENS) && (cnt == SHOW_LAST);
        if (cnt == SHOW_LAST) begin
          cnt       <= '0;
          state     <= ST_DEAD;
          digit_sel <= (digit_sel == DIG_UNITS) ? DIG_TENS : DIG_UNITS;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule
